// File: rtl/noc_pkg.sv
// Shared NoC definitions: direction codes, port count and the legality check for routed directions.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int DIR_W     = 3;

  typedef enum logic [DIR_W-1:0] {
    DIR_LOCAL = 3'd0,
    DIR_NORTH = 3'd1,
    DIR_EAST  = 3'd2,
    DIR_SOUTH = 3'd3,
    DIR_WEST  = 3'd4
  } dir_t;

  function automatic logic dir_is_legal(input logic [DIR_W-1:0] dir);
    return dir <= DIR_WEST;
  endfunction

endpackage

// File: rtl/noc_out_fifo.sv
// Per-port flit FIFO; head visible one cycle after a push into an empty FIFO, never bypassed.
// A full FIFO refuses a push even when popping in the same cycle; storage is cleared on reset.
module noc_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/noc_output_stage.sv
// Steers routed flits into five per-port FIFOs (1-cycle latency); in_ready drops only when the target port is full.
// Illegal directions are always accepted and counted as drops; NOC_OUT_STATS_EN adds per-port pop counters on fwd_cnt.
module noc_output_stage
  import noc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [DIR_W-1:0]           in_dir,
  output logic [NUM_PORTS-1:0]       out_valid,
  input  logic [NUM_PORTS-1:0]       out_ready,
  output logic [NUM_PORTS*WIDTH-1:0] out_data,
  output logic                       drop_err,
  output logic [7:0]                 drop_cnt
`ifdef NOC_OUT_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]    fwd_cnt
`endif
);

  localparam int NUM_CODES = 1 << DIR_W;

  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] fifo_push;
  logic [NUM_PORTS-1:0] fifo_pop;
  logic [NUM_CODES-1:0] full_by_code;
  logic                 dir_legal;
  logic                 accept;
  logic                 drop_evt;
  logic                 drop_err_q, drop_err_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  // Widened so every 3-bit code indexes a real bit; illegal codes read as never full.
  assign full_by_code = {{(NUM_CODES - NUM_PORTS){1'b0}}, fifo_full};
  assign dir_legal    = dir_is_legal(in_dir);
  assign in_ready     = dir_legal ? !full_by_code[in_dir] : 1'b1;
  assign accept       = in_valid && in_ready;
  assign drop_evt     = accept && !dir_legal;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [WIDTH-1:0] head;

    assign fifo_push[p] = accept && dir_legal && (in_dir == DIR_W'(p));
    assign out_valid[p] = !fifo_empty[p];
    assign fifo_pop[p]  = out_valid[p] && out_ready[p];

    noc_out_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push[p]),
      .push_dat (in_data),
      .pop      (fifo_pop[p]),
      .full     (fifo_full[p]),
      .empty    (fifo_empty[p]),
      .head     (head)
    );

    assign out_data[p*WIDTH +: WIDTH] = head;
  end

  always_comb begin
    drop_err_d = drop_err_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_evt) begin
      drop_err_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_err_q <= drop_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_err = drop_err_q;
  assign drop_cnt = drop_cnt_q;

`ifdef NOC_OUT_STATS_EN
  logic [15:0] fwd_cnt_q [NUM_PORTS];
  logic [15:0] fwd_cnt_d [NUM_PORTS];

  // Counters wrap naturally at 16 bits.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      fwd_cnt_d[p] = fwd_cnt_q[p] + (fifo_pop[p] ? 16'd1 : 16'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        fwd_cnt_q[p] <= '0;
      end
    end else begin
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stats
    assign fwd_cnt[p*16 +: 16] = fwd_cnt_q[p];
  end
`endif

endmodule

// File: tb/tb_noc_output_stage.sv
// Scoreboard bench for noc_output_stage: occupancy/drop reference model plus per-port expected-data queues.
module tb_noc_output_stage;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int NP    = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic [2:0]        in_dir = '0;
  logic [NP-1:0]     out_valid;
  logic [NP-1:0]     out_ready = '0;
  logic [NP*WIDTH-1:0] out_data;
  logic              drop_err;
  logic [7:0]        drop_cnt;
`ifdef NOC_OUT_STATS_EN
  logic [NP*16-1:0]  fwd_cnt;
  logic [15:0]       fwd_m [NP];
`endif

  noc_output_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_err  (drop_err),
    .drop_cnt  (drop_cnt)
`ifdef NOC_OUT_STATS_EN
    ,
    .fwd_cnt   (fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: expected data per port, occupancy, drop bookkeeping.
  logic [WIDTH-1:0] exp_q [NP][$];
  int               occ [NP];
  int               drop_m = 0;
  bit               err_m = 1'b0;
  bit               m_legal, m_rdy;
  logic [WIDTH-1:0] mon_e;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: checks handshake/status each cycle, then advances by the upcoming edge.
  always @(negedge clk) begin
    #1;
    if (rst !== 1'b1) begin
      for (int p = 0; p < NP; p++) begin
        occ[p] = 0;
        exp_q[p].delete();
`ifdef NOC_OUT_STATS_EN
        fwd_m[p] = '0;
`endif
      end
      drop_m = 0;
      err_m  = 1'b0;
    end else begin
      m_legal = (in_dir < 3'd5);
      m_rdy   = m_legal ? (occ[in_dir] < DEPTH) : 1'b1;
      check("in_ready", in_ready, m_rdy);
      check("drop_cnt", drop_cnt, drop_m);
      check("drop_err", drop_err, err_m);
      for (int p = 0; p < NP; p++) begin
        check("out_valid", out_valid[p], occ[p] > 0);
`ifdef NOC_OUT_STATS_EN
        check("fwd_cnt", fwd_cnt[p*16 +: 16], fwd_m[p]);
`endif
      end
      for (int p = 0; p < NP; p++) begin
        if (occ[p] > 0 && out_ready[p]) begin
          occ[p]--;
`ifdef NOC_OUT_STATS_EN
          fwd_m[p] = fwd_m[p] + 16'd1;
`endif
        end
      end
      if (in_valid && m_rdy) begin
        if (m_legal) begin
          occ[in_dir]++;
          exp_q[in_dir].push_back(in_data);
        end else begin
          err_m = 1'b1;
          if (drop_m < 255) drop_m++;
        end
      end
    end
  end

  // Monitor: every output handshake must match the head of that port's expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int p = 0; p < NP; p++) begin
        if (out_valid[p] && out_ready[p]) begin
          if (exp_q[p].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_pop: port %0d popped %0h with nothing expected", p, out_data[p*WIDTH +: WIDTH]);
          end else begin
            mon_e = exp_q[p].pop_front();
            check("out_data", out_data[p*WIDTH +: WIDTH], mon_e);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one flit and hold it until accepted; returns one step after the accepting edge.
  task automatic send(input logic [2:0] d, input logic [WIDTH-1:0] v);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_dir   = d;
    in_data  = v;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waited++;
      if (waited >= 20) begin
        timeout_fail("send");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int pending;
    out_ready = '1;
    in_valid  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      pending = 0;
      for (int p = 0; p < NP; p++) pending += exp_q[p].size();
      if (pending == 0 && out_valid == '0) return;
      cyc(1);
    end
    timeout_fail("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, '0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    rst = 1'b1;
    cyc(1);

    // Single flit to EAST, visible one cycle after acceptance, then popped.
    out_ready = '1;
    send(3'd2, 32'hDEADBEEF);
    check("east_vld", out_valid, 5'b00100);
    check("east_dat", out_data[2*WIDTH +: WIDTH], 32'hDEADBEEF);
    cyc(1);
    check("east_gone", out_valid, 5'b00000);

    // NORTH stalled: fills after four, WEST still flows, then 1..5 drain in order.
    out_ready = 5'b11101;
    for (int v = 1; v <= 4; v++) send(3'd1, WIDTH'(v));
    in_dir = 3'd1;
    #1;
    check("north_full_rdy", in_ready, 1'b0);
    send(3'd4, 32'h5757_0000);
    check("west_vld", out_valid[4], 1'b1);
    check("west_dat", out_data[4*WIDTH +: WIDTH], 32'h5757_0000);
    check("north_held", out_valid[1], 1'b1);
    in_valid = 1'b1;
    in_dir   = 3'd1;
    in_data  = 32'd5;
    cyc(3);
    out_ready = '1;
    send(3'd1, 32'd5);
    drain();

    // Illegal direction: accepted, discarded, counted; counter saturates.
    send(3'd6, 32'h0000_0066);
    check("drop_err_1", drop_err, 1'b1);
    check("drop_cnt_1", drop_cnt, 8'd1);
    check("drop_no_vld", out_valid, 5'b00000);
    for (int i = 0; i < 300; i++) send(3'(5 + $urandom_range(2)), $urandom);
    check("drop_sat", drop_cnt, 8'd255);
    check("drop_err_sticky", drop_err, 1'b1);

    // SOUTH at occupancy 2 with push and pop every cycle, then fill to confirm occupancy.
    out_ready = 5'b10111;
    send(3'd3, 32'hA000_0001);
    send(3'd3, 32'hA000_0002);
    out_ready = '1;
    for (int i = 0; i < 10; i++) send(3'd3, 32'hB000_0000 | WIDTH'(i));
    out_ready = 5'b10111;
    send(3'd3, 32'hC000_0001);
    send(3'd3, 32'hC000_0002);
    in_dir = 3'd3;
    #1;
    check("south_occ_full", in_ready, 1'b0);
    drain();

    // Asynchronous reset with flits buffered.
    out_ready = '0;
    send(3'd0, 32'h1111_1111);
    send(3'd1, 32'h2222_2222);
    send(3'd2, 32'h3333_3333);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_vld", out_valid, 5'b00000);
    check("arst_dat", out_data, '0);
    check("arst_drop_cnt", drop_cnt, 8'd0);
    check("arst_drop_err", drop_err, 1'b0);
    cyc(2);
    rst    = 1'b1;
    in_dir = 3'd1;
    #1;
    check("post_rst_rdy", in_ready, 1'b1);
    check("post_rst_vld", out_valid, 5'b00000);
`ifdef NOC_OUT_STATS_EN
    check("post_rst_fwd", fwd_cnt, '0);
`endif
    cyc(1);

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(1));
      in_dir    = ($urandom_range(7) < 6) ? 3'($urandom_range(4)) : 3'(5 + $urandom_range(2));
      in_data   = $urandom;
      out_ready = 5'($urandom);
      cyc(1);
    end
    drain();
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
